// File: rtl/mmio_uart_fifo.sv
// MMIO UART peripheral: 8N1 serial TX/RX with power-of-two FIFOs,
// status/sticky-error reporting and FIFO flush through a CTRL register.
module mmio_uart_fifo #(
    parameter int SERIAL_WCNT = 100,
    parameter int TX_AW       = 4,
    parameter int RX_AW       = 4
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        RXD,
    output logic        TXD,
    input  logic        OE,
    input  logic        WE,
    input  logic [3:0]  ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        VALID,
    output logic        RX_IRQ
);

    localparam int CW       = $clog2(SERIAL_WCNT);
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam int RX_DEPTH = 1 << RX_AW;

    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_LAST = CW'(SERIAL_WCNT - 1);
    // Start bit is confirmed half a bit time after the synced falling edge.
    localparam logic [CW-1:0]  CNT_HALF = CW'(SERIAL_WCNT / 2 - 1);
    localparam logic [TX_AW:0] TX_ONE   = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [TX_AW:0] TX_FULL  = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_ONE   = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW:0] RX_FULL  = {1'b1, {RX_AW{1'b0}}};

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic rd_s, wr_s, sel_data_s, sel_status_s, sel_ctrl_s, ctrl_wr_s;
    logic tx_flush_s, rx_flush_s, unused_s;

    assign rd_s         = OE & ~WE;
    assign wr_s         = OE & WE;
    assign sel_data_s   = (ADDR == 4'h0);
    assign sel_status_s = (ADDR == 4'h4);
    assign sel_ctrl_s   = (ADDR == 4'h8);
    assign ctrl_wr_s    = wr_s & sel_ctrl_s;
    assign tx_flush_s   = ctrl_wr_s & WDATA[3];
    assign rx_flush_s   = ctrl_wr_s & WDATA[4];
    assign unused_s     = ^WDATA[31:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem_r [TX_DEPTH];
    logic [TX_AW:0] tx_wptr_r, tx_rptr_r, tx_count_s;
    logic           tx_empty_s, tx_full_s, tx_push_req_s, tx_push_s, tx_pop_s, tx_load_ok_s;
    logic           tx_ovf_set_s;
    logic [7:0]     tx_head_s;

    assign tx_count_s    = tx_wptr_r - tx_rptr_r;
    assign tx_empty_s    = (tx_count_s == {(TX_AW+1){1'b0}});
    assign tx_full_s     = (tx_count_s == TX_FULL);
    assign tx_push_req_s = wr_s & sel_data_s;
    assign tx_push_s     = tx_push_req_s & ~tx_full_s & ~tx_flush_s;
    assign tx_ovf_set_s  = tx_push_req_s & tx_full_s;
    assign tx_head_s     = tx_mem_r[tx_rptr_r[TX_AW-1:0]];
    assign tx_load_ok_s  = ~tx_empty_s & ~tx_flush_s;

    // TX FIFO storage
    always_ff @(posedge CLK) begin
        if (tx_push_s) tx_mem_r[tx_wptr_r[TX_AW-1:0]] <= WDATA[7:0];
    end

    // TX FIFO pointers; flush drops queued bytes but not the one in the shifter
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            tx_wptr_r <= {(TX_AW+1){1'b0}};
            tx_rptr_r <= {(TX_AW+1){1'b0}};
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + TX_ONE;
            if (tx_flush_s)    tx_rptr_r <= tx_wptr_r;
            else if (tx_pop_s) tx_rptr_r <= tx_rptr_r + TX_ONE;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t      tx_state_r, tx_state_s;
    logic [CW-1:0]  tx_cnt_r, tx_cnt_s;
    logic [2:0]     tx_bit_r, tx_bit_s;
    logic [7:0]     tx_shift_r, tx_shift_s;
    logic           txd_r, txd_s;

    // TX next-state, line level and FIFO pop
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        txd_s      = txd_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                txd_s = 1'b1;
                if (tx_load_ok_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_head_s;
                    tx_cnt_s   = CNT_ZERO;
                    tx_state_s = TX_START;
                    txd_s      = 1'b0;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s   = CNT_ZERO;
                    tx_bit_s   = 3'd0;
                    tx_state_s = TX_DATA;
                    txd_s      = tx_shift_r[0];
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = TX_STOP;
                        txd_s      = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        txd_s      = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = CNT_ZERO;
                    // Chain straight into the next start bit when more data is queued.
                    if (tx_load_ok_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_s = tx_head_s;
                        tx_state_s = TX_START;
                        txd_s      = 1'b0;
                    end else begin
                        tx_state_s = TX_IDLE;
                        txd_s      = 1'b1;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                txd_s      = 1'b1;
            end
        endcase
    end

    // TX state register
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            txd_r      <= txd_s;
        end
    end

    // ---------------- RX path ----------------
    logic rxd_meta_r, rxd_sync_r, rxd_prev_r;

    // RXD synchroniser and edge-detect history
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= RXD;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    rx_state_t      rx_state_r, rx_state_s;
    logic [CW-1:0]  rx_cnt_r, rx_cnt_s;
    logic [2:0]     rx_bit_r, rx_bit_s;
    logic [7:0]     rx_shift_r, rx_shift_s;
    logic           rx_push_req_s, frame_err_set_s;

    // RX next-state and sampling
    always_comb begin
        rx_state_s      = rx_state_r;
        rx_cnt_s        = rx_cnt_r;
        rx_bit_s        = rx_bit_r;
        rx_shift_s      = rx_shift_r;
        rx_push_req_s   = 1'b0;
        frame_err_set_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (rxd_prev_r && !rxd_sync_r) begin
                    rx_state_s = RX_START;
                    rx_cnt_s   = CNT_ZERO;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_s = CNT_ZERO;
                    rx_bit_s = 3'd0;
                    if (rxd_sync_r) rx_state_s = RX_IDLE;
                    else            rx_state_s = RX_DATA;
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = CNT_ZERO;
                    rx_shift_s = {rxd_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) rx_state_s = RX_STOP;
                    else                  rx_bit_s   = rx_bit_r + 3'd1;
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s = CNT_ZERO;
                    if (rxd_sync_r) begin
                        rx_push_req_s = 1'b1;
                        rx_state_s    = RX_IDLE;
                    end else begin
                        frame_err_set_s = 1'b1;
                        rx_state_s      = RX_WAIT;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + CNT_ONE;
                end
            end
            RX_WAIT: begin
                if (rxd_sync_r) rx_state_s = RX_IDLE;
                else            rx_state_s = RX_WAIT;
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem_r [RX_DEPTH];
    logic [RX_AW:0] rx_wptr_r, rx_rptr_r, rx_wptr_nxt_s, rx_rptr_nxt_s, rx_count_s;
    logic           rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_ovr_set_s;
    logic [7:0]     rx_head_s;

    assign rx_count_s   = rx_wptr_r - rx_rptr_r;
    assign rx_empty_s   = (rx_count_s == {(RX_AW+1){1'b0}});
    assign rx_full_s    = (rx_count_s == RX_FULL);
    assign rx_pop_s     = rd_s & sel_data_s & ~rx_empty_s;
    // A CPU pop in the same cycle frees the slot the incoming byte needs.
    assign rx_push_s    = rx_push_req_s & ~rx_flush_s & (~rx_full_s | rx_pop_s);
    assign rx_ovr_set_s = rx_push_req_s & ~rx_flush_s & rx_full_s & ~rx_pop_s;
    assign rx_head_s    = rx_mem_r[rx_rptr_r[RX_AW-1:0]];

    // RX FIFO next pointers
    always_comb begin
        rx_wptr_nxt_s = rx_wptr_r;
        rx_rptr_nxt_s = rx_rptr_r;
        if (rx_flush_s) begin
            rx_rptr_nxt_s = rx_wptr_r;
        end else begin
            if (rx_push_s) rx_wptr_nxt_s = rx_wptr_r + RX_ONE;
            else           rx_wptr_nxt_s = rx_wptr_r;
            if (rx_pop_s)  rx_rptr_nxt_s = rx_rptr_r + RX_ONE;
            else           rx_rptr_nxt_s = rx_rptr_r;
        end
    end

    // RX FIFO storage
    always_ff @(posedge CLK) begin
        if (rx_push_s) rx_mem_r[rx_wptr_r[RX_AW-1:0]] <= rx_shift_r;
    end

    // RX FIFO pointers
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rx_wptr_r <= {(RX_AW+1){1'b0}};
            rx_rptr_r <= {(RX_AW+1){1'b0}};
        end else begin
            rx_wptr_r <= rx_wptr_nxt_s;
            rx_rptr_r <= rx_rptr_nxt_s;
        end
    end

    // ---------------- Sticky flags and register read ----------------
    logic tx_ovf_r, rx_ovr_r, frame_err_r;

    // Sticky error flags; a set beats a simultaneous clear
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            tx_ovf_r    <= 1'b0;
            rx_ovr_r    <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (tx_ovf_set_s)                 tx_ovf_r <= 1'b1;
            else if (ctrl_wr_s && WDATA[0])   tx_ovf_r <= 1'b0;
            if (rx_ovr_set_s)                 rx_ovr_r <= 1'b1;
            else if (ctrl_wr_s && WDATA[1])   rx_ovr_r <= 1'b0;
            if (frame_err_set_s)              frame_err_r <= 1'b1;
            else if (ctrl_wr_s && WDATA[2])   frame_err_r <= 1'b0;
        end
    end

    logic        tx_idle_s;
    logic [31:0] status_s, rdata_s, rdata_r;
    logic        valid_r, rx_irq_r;

    assign tx_idle_s = tx_empty_s & (tx_state_r == TX_IDLE);
    assign status_s  = {tx_idle_s, frame_err_r, rx_ovr_r, tx_ovf_r, 3'b000,
                        9'(rx_count_s), 7'b0000000, 9'(tx_count_s)};

    // Read data mux
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (sel_data_s) begin
            if (rx_empty_s) rdata_s = 32'h8000_0000;
            else            rdata_s = {24'h00_0000, rx_head_s};
        end else if (sel_status_s) begin
            rdata_s = status_s;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Registered bus outputs and RX interrupt
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rdata_r  <= 32'h0000_0000;
            valid_r  <= 1'b0;
            rx_irq_r <= 1'b0;
        end else begin
            valid_r  <= rd_s;
            if (rd_s) rdata_r <= rdata_s;
            rx_irq_r <= (rx_wptr_nxt_s != rx_rptr_nxt_s);
        end
    end

    assign TXD    = txd_r;
    assign RDATA  = rdata_r;
    assign VALID  = valid_r;
    assign RX_IRQ = rx_irq_r;

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed bench for mmio_uart_fifo: table-driven bus transactions plus
// hand-written serial sequences for TX framing, RX overrun, framing errors and reset.
module tb_mmio_uart_fifo;
    localparam int W = 4;
    localparam int OP_WR = 0, OP_RD = 1, OP_WAIT = 2;
    localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_CTRL = 4'h8;

    logic        CLK = 1'b0, RST_X = 1'b0, RXD = 1'b1, OE = 1'b0, WE = 1'b0;
    logic [3:0]  ADDR = 4'h0;
    logic [31:0] WDATA = 32'h0;
    logic        TXD, VALID, RX_IRQ;
    logic [31:0] RDATA;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          op;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        irq;
    } vec_t;
    vec_t tbl[$];

    mmio_uart_fifo #(.SERIAL_WCNT(W), .TX_AW(2), .RX_AW(2)) dut (
        .CLK(CLK), .RST_X(RST_X), .RXD(RXD), .TXD(TXD), .OE(OE), .WE(WE),
        .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .VALID(VALID), .RX_IRQ(RX_IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        OE = 1'b1; WE = 1'b1; ADDR = a; WDATA = d;
        tick(1);
        OE = 1'b0; WE = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [3:0] a,
                            input logic [31:0] exp, input logic exp_irq);
        OE = 1'b1; WE = 1'b0; ADDR = a;
        tick(1);
        OE = 1'b0;
        check({name, " valid"}, 32'(VALID), 32'd1);
        check({name, " rdata"}, RDATA, exp);
        check({name, " irq"}, 32'(RX_IRQ), 32'(exp_irq));
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_WR:   bus_write(tbl[i].addr, tbl[i].data);
                OP_RD:   bus_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp, tbl[i].irq);
                default: tick(int'(tbl[i].data));
            endcase
        end
        tbl.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RXD = 1'b0;
        tick(W);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(W);
        end
        RXD = stop_bit;
        tick(W);
        RXD = 1'b1;
        tick(W);
    endtask

    logic [19:0] seq;

    initial begin
        // 1. reset state
        tick(3);
        check("rst txd", 32'(TXD), 32'd1);
        check("rst valid", 32'(VALID), 32'd0);
        check("rst rdata", RDATA, 32'h0);
        check("rst irq", 32'(RX_IRQ), 32'd0);
        RST_X = 1'b1;
        tick(2);
        OE = 1'b1; WE = 1'b0; ADDR = A_STAT;
        check("valid before edge", 32'(VALID), 32'd0);
        tick(1);
        OE = 1'b0;
        check("status valid", 32'(VALID), 32'd1);
        check("status after reset", RDATA, 32'h8000_0000);
        tick(1);
        check("valid one cycle", 32'(VALID), 32'd0);
        check("idle txd", 32'(TXD), 32'd1);
        tbl.push_back('{OP_RD, A_CTRL, 32'h0, 32'h0000_0000, 1'b0});
        tbl.push_back('{OP_RD, 4'hC,   32'h0, 32'h0000_0000, 1'b0});
        tbl.push_back('{OP_RD, A_DATA, 32'h0, 32'h8000_0000, 1'b0});
        tbl.push_back('{OP_WR, A_STAT, 32'hFFFF_FFFF, 32'h0, 1'b0});
        tbl.push_back('{OP_RD, A_STAT, 32'h0, 32'h8000_0000, 1'b0});
        run_table();

        // 2. TX framing of 0xA5, 0x3C back-to-back
        seq = 20'b0101001011_0001111001;
        bus_write(A_DATA, 32'h0000_00A5);
        bus_write(A_DATA, 32'h0000_003C);
        for (int j = 0; j < 20; j++) begin
            for (int k = 0; k < W; k++) begin
                check($sformatf("txd bit%0d clk%0d", j, k), 32'(TXD), 32'(seq[19-j]));
                tick(1);
            end
        end
        check("txd idle after frames", 32'(TXD), 32'd1);
        tick(4);

        // 3. TX overflow, clear, flush
        for (int i = 0; i < 6; i++)
            tbl.push_back('{OP_WR, A_DATA, 32'(8'h10 + i), 32'h0, 1'b0});
        tbl.push_back('{OP_RD,   A_STAT, 32'h0, 32'h1000_0004, 1'b0});
        tbl.push_back('{OP_WR,   A_CTRL, 32'h1, 32'h0, 1'b0});
        tbl.push_back('{OP_RD,   A_STAT, 32'h0, 32'h0000_0004, 1'b0});
        tbl.push_back('{OP_WR,   A_CTRL, 32'h8, 32'h0, 1'b0});
        tbl.push_back('{OP_RD,   A_STAT, 32'h0, 32'h0000_0000, 1'b0});
        tbl.push_back('{OP_WAIT, A_DATA, 32'd40, 32'h0, 1'b0});
        tbl.push_back('{OP_RD,   A_STAT, 32'h0, 32'h8000_0000, 1'b0});
        run_table();

        // 4. RX overrun with five frames, then drain
        for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b1);
        tick(4);
        tbl.push_back('{OP_RD, A_STAT, 32'h0, 32'hA004_0000, 1'b1});
        tbl.push_back('{OP_RD, A_DATA, 32'h0, 32'h0000_0011, 1'b1});
        tbl.push_back('{OP_RD, A_DATA, 32'h0, 32'h0000_0012, 1'b1});
        tbl.push_back('{OP_RD, A_DATA, 32'h0, 32'h0000_0013, 1'b1});
        tbl.push_back('{OP_RD, A_DATA, 32'h0, 32'h0000_0014, 1'b0});
        tbl.push_back('{OP_RD, A_DATA, 32'h0, 32'h8000_0000, 1'b0});
        tbl.push_back('{OP_WR, A_CTRL, 32'h2, 32'h0, 1'b0});
        tbl.push_back('{OP_RD, A_STAT, 32'h0, 32'h8000_0000, 1'b0});
        run_table();

        // 5. framing error and start-bit glitch
        send_frame(8'h77, 1'b1);
        bus_read("good frame status", A_STAT, 32'h8001_0000, 1'b1);
        send_frame(8'h55, 1'b0);
        bus_read("frame err status", A_STAT, 32'hC001_0000, 1'b1);
        RXD = 1'b0;
        tick(1);
        RXD = 1'b1;
        tick(20);
        bus_read("after glitch status", A_STAT, 32'hC001_0000, 1'b1);
        bus_read("after glitch data", A_DATA, 32'h0000_0077, 1'b0);
        send_frame(8'h5A, 1'b1);
        bus_read("post glitch frame", A_DATA, 32'h0000_005A, 1'b0);
        bus_write(A_CTRL, 32'h4);
        bus_read("frame err cleared", A_STAT, 32'h8000_0000, 1'b0);

        // 6. reset mid TX and mid RX frame
        send_frame(8'h42, 1'b1);
        bus_write(A_DATA, 32'h0000_0081);
        bus_write(A_DATA, 32'h0000_0001);
        bus_write(A_DATA, 32'h0000_0002);
        RXD = 1'b0;
        tick(10);
        check("txd mid frame", 32'(TXD), 32'd0);
        check("irq before reset", 32'(RX_IRQ), 32'd1);
        #2;
        RST_X = 1'b0;
        #1;
        check("async rst txd", 32'(TXD), 32'd1);
        check("async rst valid", 32'(VALID), 32'd0);
        check("async rst rdata", RDATA, 32'h0);
        check("async rst irq", 32'(RX_IRQ), 32'd0);
        RXD = 1'b1;
        tick(3);
        RST_X = 1'b1;
        tick(2);
        bus_read("status after mid reset", A_STAT, 32'h8000_0000, 1'b0);
        bus_read("data after mid reset", A_DATA, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 44; i++) begin
            check($sformatf("txd stays idle %0d", i), 32'(TXD), 32'd1);
            tick(1);
        end
        bus_read("final status", A_STAT, 32'h8000_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
